multicycle_controller: RTL and testbench

Parametrised multi-cycle control unit for the RISC-V core. It replaces the single-cycle opcode decoder with a state machine that sequences fetch, decode, execute, memory and writeback. It adds wait-state handshakes to instruction and data memory, optional JAL/JALR support, a memory-timeout watchdog and illegal-opcode trapping. It sits between the instruction register and the datapath mux, ALU and register-file enables.

---
 rtl/multicycle_controller_if.sv | 35 +++
 rtl/multicycle_controller.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control-unit bundle: opcode and memory ready flags toward the controller,
// datapath strobes, sticky trap flags and debug state back out.
interface multicycle_controller_if #(
   parameter int OPCODE_W = 7
);
   logic [OPCODE_W-1:0] Opcode;
   logic                imem_ready;
   logic                dmem_ready;
   logic                InstrRead;
   logic                IRWrite;
   logic                PCWrite;
   logic                ALUSrc;
   logic                MemtoReg;
   logic                RegWrite;
   logic                MemRead;
   logic                MemWrite;
   logic [1:0]          ALUOp;
   logic                Branch;
   logic                Jump;
   logic                illegal;
   logic                mem_err;
   logic [2:0]          state;

   modport master (
      output Opcode, imem_ready, dmem_ready,
      input  InstrRead, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
             MemRead, MemWrite, ALUOp, Branch, Jump, illegal, mem_err, state
   );

   modport slave (
      input  Opcode, imem_ready, dmem_ready,
      output InstrRead, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
             MemRead, MemWrite, ALUOp, Branch, Jump, illegal, mem_err, state
   );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V control FSM (FETCH/DECODE/EXEC/MEM/WB); zero-wait latency 3-5 cycles per instruction,
// stalls in FETCH/MEM while memory ready is low, traps on illegal opcode or watchdog expiry.
module multicycle_controller #(
   parameter int OPCODE_W     = 7,
   parameter bit SUPPORT_JUMP = 1'b1,
   parameter int MEM_TIMEOUT  = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   multicycle_controller_if.slave ctl_if
);

   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT - 1);

   localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(7'b0110011);
   localparam logic [OPCODE_W-1:0] OP_I    = OPCODE_W'(7'b0010011);
   localparam logic [OPCODE_W-1:0] OP_U    = OPCODE_W'(7'b0110111);
   localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(7'b0000011);
   localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(7'b0100011);
   localparam logic [OPCODE_W-1:0] OP_BR   = OPCODE_W'(7'b1100011);
   localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(7'b1101111);
   localparam logic [OPCODE_W-1:0] OP_JALR = OPCODE_W'(7'b1100111);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   state_t              state_q, state_d;
   logic [OPCODE_W-1:0] op_q, op_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                illegal_q, illegal_d;
   logic                mem_err_q, mem_err_d;

   logic       instr_read, ir_write, pc_write, alu_src, mem_to_reg, reg_write;
   logic       mem_read, mem_write, branch, jump;
   logic [1:0] alu_op;

   logic is_r, is_i, is_u, is_lw, is_sw, is_br, is_jal, is_jalr;

   function automatic logic op_legal(input logic [OPCODE_W-1:0] op);
      return (op == OP_R) || (op == OP_I) || (op == OP_U) || (op == OP_LW) ||
             (op == OP_SW) || (op == OP_BR) ||
             (SUPPORT_JUMP && ((op == OP_JAL) || (op == OP_JALR)));
   endfunction

   // Post-decode behaviour keys off the latched opcode only.
   assign is_r    = (op_q == OP_R);
   assign is_i    = (op_q == OP_I);
   assign is_u    = (op_q == OP_U);
   assign is_lw   = (op_q == OP_LW);
   assign is_sw   = (op_q == OP_SW);
   assign is_br   = (op_q == OP_BR);
   assign is_jal  = (op_q == OP_JAL);
   assign is_jalr = (op_q == OP_JALR);

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      illegal_d  = illegal_q;
      mem_err_d  = mem_err_q;
      instr_read = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      branch     = 1'b0;
      jump       = 1'b0;
      alu_op     = 2'b00;

      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            instr_read = 1'b1;
            if (ctl_if.imem_ready) begin
               ir_write = 1'b1;
               state_d  = S_DECODE;
            end else if (cnt_q == CNT_MAX) begin
               state_d   = S_TRAP;
               mem_err_d = 1'b1;
            end
         end
         S_DECODE: begin
            op_d = ctl_if.Opcode;
            if (op_legal(ctl_if.Opcode)) begin
               state_d = S_EXEC;
            end else begin
               state_d   = S_TRAP;
               illegal_d = 1'b1;
            end
         end
         S_EXEC: begin
            alu_src = is_lw | is_sw | is_i | is_u | is_jalr;
            if (is_r || is_i)  alu_op = 2'b10;
            else if (is_u)     alu_op = 2'b11;
            else if (is_br)    alu_op = 2'b01;
            else               alu_op = 2'b00;
            if (is_br) begin
               branch   = 1'b1;
               pc_write = 1'b1;
               state_d  = S_FETCH;
            end else if (is_lw || is_sw) begin
               state_d = S_MEM;
            end else if (is_r || is_i || is_u || is_jal || is_jalr) begin
               state_d = S_WB;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_MEM: begin
            mem_read  = is_lw;
            mem_write = is_sw;
            if (ctl_if.dmem_ready) begin
               if (is_sw) begin
                  pc_write = 1'b1;
                  state_d  = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (cnt_q == CNT_MAX) begin
               state_d   = S_TRAP;
               mem_err_d = 1'b1;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            pc_write   = 1'b1;
            mem_to_reg = is_lw;
            jump       = is_jal | is_jalr;
            state_d    = S_FETCH;
         end
         S_TRAP: state_d = S_TRAP;
         default: state_d = S_IDLE;
      endcase

      // Watchdog restarts on every entry to a waiting state and saturates at its limit.
      if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
         cnt_d = '0;
      end else if ((state_q == S_FETCH) && !ctl_if.imem_ready && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if ((state_q == S_MEM) && !ctl_if.dmem_ready && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         mem_err_q <= mem_err_d;
      end
   end

   assign ctl_if.InstrRead = instr_read;
   assign ctl_if.IRWrite   = ir_write;
   assign ctl_if.PCWrite   = pc_write;
   assign ctl_if.ALUSrc    = alu_src;
   assign ctl_if.MemtoReg  = mem_to_reg;
   assign ctl_if.RegWrite  = reg_write;
   assign ctl_if.MemRead   = mem_read;
   assign ctl_if.MemWrite  = mem_write;
   assign ctl_if.ALUOp     = alu_op;
   assign ctl_if.Branch    = branch;
   assign ctl_if.Jump      = jump;
   assign ctl_if.illegal   = illegal_q;
   assign ctl_if.mem_err   = mem_err_q;
   assign ctl_if.state     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction stream against a per-instruction reference model; a monitor
// aggregates strobes between fetches and compares against the queued expectations.
module tb_multicycle_controller;

   localparam int TMO = 4;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_U    = 7'b0110111;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic rst_nj = 1'b0;
   always #5 clk = ~clk;

   multicycle_controller_if #(.OPCODE_W(7)) bus ();
   multicycle_controller_if #(.OPCODE_W(7)) bus_nj ();

   multicycle_controller #(.OPCODE_W(7), .SUPPORT_JUMP(1'b1), .MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .ctl_if(bus.slave));
   multicycle_controller #(.OPCODE_W(7), .SUPPORT_JUMP(1'b0), .MEM_TIMEOUT(TMO)) dut_nj (
      .clk(clk), .rst_n(rst_nj), .ctl_if(bus_nj.slave));

   typedef struct {
      int trap_ill, trap_mem, cycles, instrread, irwrite, pcwrite, regwrite;
      int memread, memwrite, memtoreg, branch, jump, aluop, alusrc;
   } rec_t;

   rec_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   mon_en   = 1'b1;

   function automatic void chk(string name, int act, int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
      end
   endfunction

   // Instruction-level expectation: wi/wd = wait cycles before imem/dmem ready (>= TMO never comes).
   function automatic rec_t model(logic [6:0] op, int wi, int wd);
      rec_t e = '{default: 0};
      bit lw = (op == OP_LW), sw = (op == OP_SW), br = (op == OP_BR);
      bit jal = (op == OP_JAL), jalr = (op == OP_JALR);
      bit legal = (op inside {OP_R, OP_I, OP_U, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR});
      if (wi >= TMO) begin
         e.trap_mem = 1; e.cycles = TMO; e.instrread = TMO;
         return e;
      end
      e.instrread = wi + 1; e.irwrite = 1; e.cycles = wi + 2;
      if (!legal) begin
         e.trap_ill = 1;
         return e;
      end
      e.cycles += 1;
      case (op)
         OP_R, OP_I: e.aluop = 2;
         OP_U:       e.aluop = 3;
         OP_BR:      e.aluop = 1;
         default:    e.aluop = 0;
      endcase
      e.alusrc = (lw || sw || op == OP_I || op == OP_U || jalr) ? 1 : 0;
      if (br) begin
         e.branch = 1; e.pcwrite = 1;
         return e;
      end
      if (lw || sw) begin
         if (wd >= TMO) begin
            e.trap_mem = 1; e.cycles += TMO;
            if (lw) e.memread = TMO; else e.memwrite = TMO;
            return e;
         end
         e.cycles += wd + 1;
         if (lw) e.memread = wd + 1; else e.memwrite = wd + 1;
         if (sw) begin
            e.pcwrite = 1;
            return e;
         end
      end
      e.cycles += 1; e.regwrite = 1; e.pcwrite = 1;
      e.memtoreg = lw ? 1 : 0;
      e.jump = (jal || jalr) ? 1 : 0;
      return e;
   endfunction

   rec_t obs;
   bit   in_txn   = 1'b0;
   int   prev_st  = 0;
   int   trap_cnt = 0;

   task automatic close_txn();
      rec_t e;
      if (exp_q.size() == 0) begin
         chk("unexpected_txn", 1, 0);
         return;
      end
      e = exp_q.pop_front();
      chk("cycles", obs.cycles, e.cycles);
      chk("instrread", obs.instrread, e.instrread);
      chk("irwrite", obs.irwrite, e.irwrite);
      chk("pcwrite", obs.pcwrite, e.pcwrite);
      chk("regwrite", obs.regwrite, e.regwrite);
      chk("memread", obs.memread, e.memread);
      chk("memwrite", obs.memwrite, e.memwrite);
      chk("memtoreg", obs.memtoreg, e.memtoreg);
      chk("branch", obs.branch, e.branch);
      chk("jump", obs.jump, e.jump);
      chk("aluop", obs.aluop, e.aluop);
      chk("alusrc", obs.alusrc, e.alusrc);
      chk("illegal", obs.trap_ill, e.trap_ill);
      chk("mem_err", obs.trap_mem, e.trap_mem);
   endtask

   // Monitor: a transaction spans one FETCH entry to the next, or to four cycles of TRAP.
   initial begin : monitor
      int st;
      forever begin
         @(negedge clk);
         #2;
         st = int'(bus.state);
         if (!rst_n || !mon_en) begin
            in_txn = 1'b0;
         end else begin
            if (in_txn && st == 1 && prev_st != 1) begin
               close_txn();
               in_txn = 1'b0;
            end
            if (st == 1 && prev_st != 1) begin
               in_txn   = 1'b1;
               obs      = '{default: 0};
               trap_cnt = 0;
            end
            if (in_txn) begin
               if (st == 6) trap_cnt++; else obs.cycles++;
               obs.instrread += int'(bus.InstrRead);
               obs.irwrite   += int'(bus.IRWrite);
               obs.pcwrite   += int'(bus.PCWrite);
               obs.regwrite  += int'(bus.RegWrite);
               obs.memread   += int'(bus.MemRead);
               obs.memwrite  += int'(bus.MemWrite);
               obs.memtoreg  += int'(bus.MemtoReg);
               obs.branch    += int'(bus.Branch);
               obs.jump      += int'(bus.Jump);
               if (st == 3) begin
                  obs.aluop  = int'(bus.ALUOp);
                  obs.alusrc = int'(bus.ALUSrc);
               end
               obs.trap_ill = int'(bus.illegal);
               obs.trap_mem = int'(bus.mem_err);
               if (trap_cnt == 4) begin
                  close_txn();
                  in_txn = 1'b0;
               end
            end
         end
         prev_st = st;
      end
   end

   task automatic trap_reset();
      repeat (5) @(negedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Called at a negedge with the DUT in FETCH; returns at the negedge where the next FETCH starts.
   task automatic run_instr(logic [6:0] op, int wi, int wd);
      int fc = 0, mc = 0, st, prev, n = 0;
      exp_q.push_back(model(op, wi, wd));
      forever begin
         st = int'(bus.state);
         bus.imem_ready = 1'($urandom_range(0, 1));
         bus.dmem_ready = 1'($urandom_range(0, 1));
         bus.Opcode     = 7'($urandom);
         if (st == 1) begin
            bus.imem_ready = (fc == wi);
            bus.Opcode     = op;
            fc++;
         end else if (st == 2) begin
            bus.Opcode = op;
         end else if (st == 4) begin
            bus.dmem_ready = (mc == wd);
            mc++;
         end
         prev = st;
         @(posedge clk);
         @(negedge clk);
         n++;
         st = int'(bus.state);
         if (st == 1 && prev != 1) break;
         if (st == 6) begin
            trap_reset();
            break;
         end
         if (n > 60) begin
            chk("instr_budget", n, 60);
            break;
         end
      end
   endtask

   initial begin : stim
      int n;
      int hits;
      int held;
      logic [6:0] ops [8];
      ops = '{OP_R, OP_I, OP_U, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR};
      bus.Opcode = '0;    bus.imem_ready = 1'b0;    bus.dmem_ready = 1'b0;
      bus_nj.Opcode = '0; bus_nj.imem_ready = 1'b0; bus_nj.dmem_ready = 1'b0;

      #2;
      chk("rst_state", int'(bus.state), 0);
      chk("rst_strobes", int'({bus.InstrRead, bus.IRWrite, bus.PCWrite, bus.ALUSrc, bus.MemtoReg,
          bus.RegWrite, bus.MemRead, bus.MemWrite, bus.ALUOp, bus.Branch, bus.Jump}), 0);
      chk("rst_flags", int'({bus.illegal, bus.mem_err}), 0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      chk("idle_state", int'(bus.state), 0);
      chk("idle_instrread", int'(bus.InstrRead), 0);
      @(posedge clk);
      #1;
      chk("first_fetch_state", int'(bus.state), 1);
      chk("first_instrread", int'(bus.InstrRead), 1);
      @(negedge clk);

      run_instr(OP_R, 0, 0);
      run_instr(OP_LW, 0, 3);
      run_instr(OP_BR, 0, 0);
      run_instr(OP_JAL, 0, 0);
      run_instr(OP_JALR, 1, 0);
      run_instr(OP_SW, 0, 0);
      run_instr(OP_I, 2, 1);
      run_instr(OP_U, 0, 0);
      run_instr(OP_R, TMO, 0);
      run_instr(OP_R, TMO - 1, 0);
      run_instr(OP_SW, 0, TMO);
      run_instr(OP_LW, 0, TMO - 1);
      run_instr(7'b1111111, 0, 0);

      for (int k = 0; k < 60; k++) begin
         logic [6:0] op;
         int wi, wd;
         op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 7)] : 7'($urandom);
         wi = ($urandom_range(0, 9) == 0) ? TMO : int'($urandom_range(0, 3));
         wd = ($urandom_range(0, 9) == 0) ? TMO : int'($urandom_range(0, 3));
         run_instr(op, wi, wd);
      end

      // Reset during a store's MEM phase must drop MemWrite at once.
      #3 mon_en = 1'b0;
      bus.Opcode = OP_SW; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (bus.state != 3'd4 && n < 20);
      chk("sw_reach_mem", int'(bus.state), 4);
      chk("sw_memwrite_on", int'(bus.MemWrite), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_memwrite", int'(bus.MemWrite), 0);
      chk("abort_state", int'(bus.state), 0);
      chk("abort_flags", int'({bus.illegal, bus.mem_err}), 0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      chk("restart_state", int'(bus.state), 1);
      chk("restart_instrread", int'(bus.InstrRead), 1);
      @(negedge clk);
      run_instr(OP_R, 0, 0);
      #3 mon_en = 1'b0;
      chk("exp_queue_left", exp_q.size(), 0);

      // Without jump support JAL must trap and hold until reset.
      @(negedge clk);
      #1 rst_nj = 1'b1;
      bus_nj.imem_ready = 1'b1;
      bus_nj.Opcode     = OP_JAL;
      repeat (3) @(posedge clk);
      #1;
      chk("nj_trap_state", int'(bus_nj.state), 6);
      chk("nj_illegal", int'(bus_nj.illegal), 1);
      chk("nj_mem_err", int'(bus_nj.mem_err), 0);
      hits = 0;
      held = 0;
      repeat (5) begin
         @(negedge clk);
         bus_nj.Opcode = 7'($urandom);
         bus_nj.dmem_ready = 1'($urandom_range(0, 1));
         #1;
         hits += int'(|{bus_nj.InstrRead, bus_nj.IRWrite, bus_nj.PCWrite, bus_nj.RegWrite,
                        bus_nj.MemRead, bus_nj.MemWrite, bus_nj.Branch, bus_nj.Jump});
         held += int'(bus_nj.illegal && bus_nj.state == 3'd6);
      end
      chk("nj_trap_strobes", hits, 0);
      chk("nj_illegal_held", held, 5);
      #1 rst_nj = 1'b0;
      #1;
      chk("nj_reset_illegal", int'(bus_nj.illegal), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
